// File: rtl/sev_seg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph encodings and width helper.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package sev_seg_pkg;

  localparam logic [7:0] SEG_OFF = 8'hFF;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // Bits needed to hold 0..value-1, never less than one.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/hex_sev_seg_decoder.sv
// Combinational hex nibble to active-low seven-segment glyph decoder.
module hex_sev_seg_decoder
  import sev_seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_glyph
);

  always_comb begin
    o_glyph = GLYPH_0;
    case (i_nib)
      4'h0:    o_glyph = GLYPH_0;
      4'h1:    o_glyph = GLYPH_1;
      4'h2:    o_glyph = GLYPH_2;
      4'h3:    o_glyph = GLYPH_3;
      4'h4:    o_glyph = GLYPH_4;
      4'h5:    o_glyph = GLYPH_5;
      4'h6:    o_glyph = GLYPH_6;
      4'h7:    o_glyph = GLYPH_7;
      4'h8:    o_glyph = GLYPH_8;
      4'h9:    o_glyph = GLYPH_9;
      4'hA:    o_glyph = GLYPH_A;
      4'hB:    o_glyph = GLYPH_B;
      4'hC:    o_glyph = GLYPH_C;
      4'hD:    o_glyph = GLYPH_D;
      4'hE:    o_glyph = GLYPH_E;
      4'hF:    o_glyph = GLYPH_F;
      default: o_glyph = GLYPH_0;
    endcase
  end

endmodule

// File: rtl/sev_seg_scan_driver.sv
// Multiplexed N-digit seven-segment driver with refresh divider, frame-coherent shadow,
// blanking, decimal points and leading-zero suppression. Optional: SEV_SEG_GHOST_BLANK_EN.
module sev_seg_scan_driver
  import sev_seg_pkg::*;
#(
  parameter int NUM_DGTS    = 5,
  parameter int REFRESH_DIV = 50000,
  parameter int LZ_SUPPRESS = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [4*NUM_DGTS-1:0] data_in,
  input  logic [NUM_DGTS-1:0]   dp_in,
  input  logic [NUM_DGTS-1:0]   blank_in,
  output logic [7:0]            seg_out,
  output logic [NUM_DGTS-1:0]   dgt_slct,
  output logic                  frame_done
);

  localparam int IDX_W = clog2(NUM_DGTS);
  localparam int CNT_W = clog2(REFRESH_DIV);

  logic [CNT_W-1:0]      r_cnt;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_en_d;
  logic [4*NUM_DGTS-1:0] r_sh_data;
  logic [NUM_DGTS-1:0]   r_sh_dp;
  logic [NUM_DGTS-1:0]   r_sh_blank;
  logic [7:0]            r_seg;
  logic [NUM_DGTS-1:0]   r_dgt;
  logic                  r_frame_done;

  logic                  w_first;
  logic                  w_last_cnt;
  logic                  w_wrap;
  logic [4*NUM_DGTS-1:0] w_data;
  logic [NUM_DGTS-1:0]   w_dp;
  logic [NUM_DGTS-1:0]   w_blank;
  logic [NUM_DGTS-1:0]   w_lz;
  logic                  w_zero_above;
  logic [3:0]            w_nib;
  logic [6:0]            w_glyph;
  logic                  w_dark;
  logic                  w_ghost;

  assign w_first    = en & ~r_en_d;
  assign w_last_cnt = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_wrap     = w_last_cnt && (r_idx == IDX_W'(NUM_DGTS - 1));

  // On the first enabled cycle the shadow is still stale, so show the inputs being loaded.
  assign w_data  = w_first ? data_in  : r_sh_data;
  assign w_dp    = w_first ? dp_in    : r_sh_dp;
  assign w_blank = w_first ? blank_in : r_sh_blank;
  assign w_nib   = w_data[4*int'(r_idx) +: 4];

  // Leading-zero mask: walk down from the top digit while every nibble seen is zero.
  always_comb begin
    w_lz         = {NUM_DGTS{1'b0}};
    w_zero_above = 1'b1;
    for (int i = NUM_DGTS - 1; i >= 0; i--) begin
      w_zero_above = w_zero_above && (w_data[4*i +: 4] == 4'h0);
      if ((LZ_SUPPRESS != 0) && (i != 0)) begin
        w_lz[i] = w_zero_above;
      end else begin
        w_lz[i] = 1'b0;
      end
    end
  end

  assign w_dark = w_blank[r_idx] | w_lz[r_idx];

`ifdef SEV_SEG_GHOST_BLANK_EN
  assign w_ghost = (32'(r_cnt) < 32'd2);
`else
  assign w_ghost = 1'b0;
`endif

  hex_sev_seg_decoder u_dec (
    .i_nib   (w_nib),
    .o_glyph (w_glyph)
  );

  // Divider, scan index, shadow capture and registered display outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt        <= {CNT_W{1'b0}};
      r_idx        <= {IDX_W{1'b0}};
      r_en_d       <= 1'b0;
      r_sh_data    <= {(4*NUM_DGTS){1'b0}};
      r_sh_dp      <= {NUM_DGTS{1'b0}};
      r_sh_blank   <= {NUM_DGTS{1'b0}};
      r_seg        <= SEG_OFF;
      r_dgt        <= {NUM_DGTS{1'b1}};
      r_frame_done <= 1'b0;
    end else if (!en) begin
      r_cnt        <= {CNT_W{1'b0}};
      r_idx        <= {IDX_W{1'b0}};
      r_en_d       <= 1'b0;
      r_seg        <= SEG_OFF;
      r_dgt        <= {NUM_DGTS{1'b1}};
      r_frame_done <= 1'b0;
    end else begin
      r_en_d       <= 1'b1;
      r_frame_done <= w_wrap;
      if (w_first || w_wrap) begin
        r_sh_data  <= data_in;
        r_sh_dp    <= dp_in;
        r_sh_blank <= blank_in;
      end
      if (w_last_cnt) begin
        r_cnt <= {CNT_W{1'b0}};
        r_idx <= w_wrap ? {IDX_W{1'b0}} : r_idx + IDX_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_ghost) begin
        r_seg <= SEG_OFF;
        r_dgt <= {NUM_DGTS{1'b1}};
      end else begin
        r_seg <= w_dark ? SEG_OFF : {~w_dp[r_idx], w_glyph};
        r_dgt <= ~(NUM_DGTS'(1) << r_idx);
      end
    end
  end

  assign seg_out    = r_seg;
  assign dgt_slct   = r_dgt;
  assign frame_done = r_frame_done;

endmodule
